break_trace: RTL and testbench

- Multi-entry data-break trace buffer for the PDP-8/I system top.
- Parametrised successor to the single-entry last-break capture.
- Records each data-break (DMA) cycle, on the rising edge of tp3 while in the break state, into a DEPTH-entry FIFO. Each entry holds extended address, memory address, memory buffer and transfer direction.
- Feeds the front-panel/diagnostic read-out. Keeps last_break_addr/last_break_data outputs for existing consumers.

---
 rtl/break_trace_pkg.sv | 27 ++
 rtl/break_trace_if.sv | 25 ++
 rtl/break_trace_fifo.sv | 73 +++++++
 rtl/break_trace.sv | 96 +++++++++
 tb/tb_break_trace.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/break_trace_pkg.sv
// break_trace shared types and width helpers.
// Entry layout is {dir, ea, ma, mb}, mb in the low bits.
package break_trace_pkg;

  localparam int DEPTH_D = 16;
  localparam int EA_W_D  = 3;
  localparam int MA_W_D  = 12;
  localparam int MB_W_D  = 12;

  localparam int MB_LSB  = 0;
  localparam int MA_LSB  = MB_LSB + MB_W_D;
  localparam int EA_LSB  = MA_LSB + MA_W_D;
  localparam int DIR_BIT = EA_LSB + EA_W_D;

  function automatic int entry_w(
    input int ea_w,
    input int ma_w,
    input int mb_w
  );
    return 1 + ea_w + ma_w + mb_w;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/break_trace_if.sv
// Trace read-out port: pop request, head entry and fill level.
// The consumer is the master, the trace buffer is the slave.
interface break_trace_if #(
  parameter int ENTRY_W = 28,
  parameter int CNT_W   = 5
);
  logic               rd_en;
  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_data;
  logic [CNT_W-1:0]   count;

  modport master (
    output rd_en,
    input  rd_valid,
    input  rd_data,
    input  count
  );

  modport slave (
    input  rd_en,
    output rd_valid,
    output rd_data,
    output count
  );
endinterface

// File: rtl/break_trace_fifo.sv
// Show-ahead trace FIFO with overwrite-oldest or drop-new on full.
// ovf flags a write that found the FIFO full with no pop.
module break_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 28
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     clear,
  input  logic                     wr,
  input  logic                     wrap,
  input  logic                     rd_en,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   cnt;
  logic          empty;
  logic          full;
  logic          pop;
  logic          acc;
  logic          ovw;

  assign empty = (cnt == '0);
  assign full  = (cnt == (PW+1)'(DEPTH));
  assign pop   = rd_en & ~empty & ~clear;
  assign acc   = wr & ~clear & (~full | pop);
  assign ovw   = wr & ~clear & full & ~pop & wrap;
  assign ovf   = wr & ~clear & full & ~pop;

  assign dout  = empty ? '0 : mem[head];
  assign valid = ~empty;
  assign count = cnt;

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (acc | ovw) begin
      mem[tail] <= din;
    end
  end

  // pointer and fill-level update
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (acc | ovw) begin
        tail <= tail + 1'b1;
      end
      if (pop | ovw) begin
        head <= head + 1'b1;
      end
      if (acc & ~pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop & ~acc) begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/break_trace.sv
// Data-break trace buffer: tp3 edge capture into a DEPTH FIFO.
// BREAK_TRACE_FILTER_EN adds a {ea,ma} address window filter.
module break_trace
  import break_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int EA_W  = 3,
  parameter int MA_W  = 12,
  parameter int MB_W  = 12
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 state_break,
  input  logic                 tp3,
  input  logic [EA_W-1:0]      ea,
  input  logic [MA_W-1:0]      ma,
  input  logic [MB_W-1:0]      mb,
  input  logic                 data_in,
  input  logic                 trace_en,
  input  logic                 wrap_mode,
  input  logic                 clear,
  output logic                 overflow,
  output logic [EA_W+MA_W-1:0] last_break_addr,
  output logic [MB_W-1:0]      last_break_data,
`ifdef BREAK_TRACE_FILTER_EN
  input  logic [EA_W+MA_W-1:0] win_lo,
  input  logic [EA_W+MA_W-1:0] win_hi,
`endif
  break_trace_if.slave         rd
);
  localparam int EW = entry_w(EA_W, MA_W, MB_W);

  logic                 tp3_q;
  logic                 win_ok;
  logic                 ev;
  logic                 ovf_ev;
  logic [EA_W+MA_W-1:0] addr;

  assign addr = {ea, ma};

`ifdef BREAK_TRACE_FILTER_EN
  assign win_ok = (addr >= win_lo) && (addr <= win_hi);
`else
  assign win_ok = 1'b1;
`endif

  assign ev = tp3 & ~tp3_q & state_break & trace_en & win_ok;

  // tp3 delayed one clock for rising-edge detect
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      tp3_q <= 1'b0;
    end else begin
      tp3_q <= tp3;
    end
  end

  // most recent capture, kept even when the FIFO drops it
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      last_break_addr <= '0;
      last_break_data <= '0;
    end else if (ev & ~clear) begin
      last_break_addr <= addr;
      last_break_data <= mb;
    end
  end

  // sticky loss flag, flushed by clear
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (ovf_ev) begin
      overflow <= 1'b1;
    end
  end

  break_trace_fifo #(
    .DEPTH(DEPTH),
    .W    (EW)
  ) u_fifo (
    .clk  (clk),
    .rst_l(rst_l),
    .clear(clear),
    .wr   (ev),
    .wrap (wrap_mode),
    .rd_en(rd.rd_en),
    .din  ({data_in, ea, ma, mb}),
    .dout (rd.rd_data),
    .valid(rd.rd_valid),
    .count(rd.count),
    .ovf  (ovf_ev)
  );
endmodule

// File: tb/tb_break_trace.sv
// Directed bench for break_trace: vector table plus
// hand sequences for full, wrap, clear, reset and filter.
module tb_break_trace;
  import break_trace_pkg::*;

  logic        clk;
  logic        rst_l;
  logic        state_break;
  logic        tp3;
  logic [2:0]  ea;
  logic [11:0] ma;
  logic [11:0] mb;
  logic        data_in;
  logic        trace_en;
  logic        wrap_mode;
  logic        clear;
  logic        overflow;
  logic [14:0] last_break_addr;
  logic [11:0] last_break_data;
`ifdef BREAK_TRACE_FILTER_EN
  logic [14:0] win_lo;
  logic [14:0] win_hi;
`endif

  int total;
  int bad;

  break_trace_if #(.ENTRY_W(28), .CNT_W(5)) rd ();

  break_trace dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .state_break    (state_break),
    .tp3            (tp3),
    .ea             (ea),
    .ma             (ma),
    .mb             (mb),
    .data_in        (data_in),
    .trace_en       (trace_en),
    .wrap_mode      (wrap_mode),
    .clear          (clear),
    .overflow       (overflow),
    .last_break_addr(last_break_addr),
    .last_break_data(last_break_data),
`ifdef BREAK_TRACE_FILTER_EN
    .win_lo         (win_lo),
    .win_hi         (win_hi),
`endif
    .rd             (rd.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sb;
    logic        tp;
    logic [14:0] addr;
    logic [11:0] mbv;
    logic        d;
    logic        rde;
    logic [4:0]  ecnt;
    logic        evld;
    logic [27:0] edat;
    logic [14:0] elba;
  } vec_t;

  vec_t vq[$];

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] ent(input int i);
    logic [14:0] a;
    a = 15'o03000 + 15'(i);
    return {i[0], a, 12'(i)};
  endfunction

  task automatic brk(
    input logic [14:0] a,
    input logic [11:0] m,
    input logic        d,
    input logic        p,
    input logic        c
  );
    @(negedge clk);
    ea = a[14:12];
    ma = a[11:0];
    mb = m;
    data_in = d;
    state_break = 1'b1;
    tp3 = 1'b1;
    rd.rd_en = p;
    clear = c;
    @(posedge clk);
    #1;
    @(negedge clk);
    tp3 = 1'b0;
    rd.rd_en = 1'b0;
    clear = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_l = 1'b0;
    state_break = 1'b0;
    tp3 = 1'b0;
    ea = '0;
    ma = '0;
    mb = '0;
    data_in = 1'b0;
    trace_en = 1'b1;
    wrap_mode = 1'b0;
    clear = 1'b0;
    rd.rd_en = 1'b0;
`ifdef BREAK_TRACE_FILTER_EN
    win_lo = 15'o00000;
    win_hi = 15'o77777;
`endif

    vq.push_back('{1,1,15'o01000,12'o1234,1,0, 1,1,{1'b1,15'o01000,12'o1234},15'o01000});
    vq.push_back('{1,0,15'o01000,12'o1234,1,0, 1,1,{1'b1,15'o01000,12'o1234},15'o01000});
    vq.push_back('{1,1,15'o01001,12'o1235,1,0, 2,1,{1'b1,15'o01000,12'o1234},15'o01001});
    vq.push_back('{1,0,15'o01001,12'o1235,1,0, 2,1,{1'b1,15'o01000,12'o1234},15'o01001});
    vq.push_back('{1,1,15'o01002,12'o1236,1,0, 3,1,{1'b1,15'o01000,12'o1234},15'o01002});
    vq.push_back('{1,0,15'o01002,12'o1236,1,0, 3,1,{1'b1,15'o01000,12'o1234},15'o01002});
    vq.push_back('{1,0,15'o01002,12'o1236,1,1, 2,1,{1'b1,15'o01001,12'o1235},15'o01002});
    vq.push_back('{1,0,15'o01002,12'o1236,1,1, 1,1,{1'b1,15'o01002,12'o1236},15'o01002});
    vq.push_back('{1,0,15'o01002,12'o1236,1,1, 0,0,28'h0,15'o01002});
    vq.push_back('{1,0,15'o01002,12'o1236,1,1, 0,0,28'h0,15'o01002});
    for (int k = 0; k < 5; k++) begin
      vq.push_back('{1,1,15'o00100,12'o0077,0,0, 1,1,{1'b0,15'o00100,12'o0077},15'o00100});
    end
    vq.push_back('{1,0,15'o00100,12'o0077,0,0, 1,1,{1'b0,15'o00100,12'o0077},15'o00100});
    vq.push_back('{0,1,15'o00200,12'o0055,0,0, 1,1,{1'b0,15'o00100,12'o0077},15'o00100});
    vq.push_back('{0,0,15'o00200,12'o0055,0,0, 1,1,{1'b0,15'o00100,12'o0077},15'o00100});
    vq.push_back('{0,0,15'o00200,12'o0055,0,1, 0,0,28'h0,15'o00100});
    vq.push_back('{1,1,15'o02000,12'o0001,1,1, 1,1,{1'b1,15'o02000,12'o0001},15'o02000});
    vq.push_back('{1,0,15'o02000,12'o0001,1,1, 0,0,28'h0,15'o02000});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 64'(rd.count), 64'd0);
    chk("rst_valid", 64'(rd.rd_valid), 64'd0);
    chk("rst_data", 64'(rd.rd_data), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_lba", 64'(last_break_addr), 64'd0);
    @(negedge clk);
    rst_l = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      state_break = vq[i].sb;
      tp3 = vq[i].tp;
      ea = vq[i].addr[14:12];
      ma = vq[i].addr[11:0];
      mb = vq[i].mbv;
      data_in = vq[i].d;
      rd.rd_en = vq[i].rde;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), 64'(rd.count), 64'(vq[i].ecnt));
      chk($sformatf("v%0d_valid", i), 64'(rd.rd_valid), 64'(vq[i].evld));
      chk($sformatf("v%0d_data", i), 64'(rd.rd_data), 64'(vq[i].edat));
      chk($sformatf("v%0d_lba", i), 64'(last_break_addr), 64'(vq[i].elba));
    end
    @(negedge clk);
    tp3 = 1'b0;
    rd.rd_en = 1'b0;

    // 17 breaks, drop mode
    do_clear();
    wrap_mode = 1'b0;
    for (int i = 0; i < 17; i++) begin
      brk(15'o03000 + 15'(i), 12'(i), i[0], 1'b0, 1'b0);
    end
    chk("drop_count", 64'(rd.count), 64'd16);
    chk("drop_head", 64'(rd.rd_data), 64'(ent(0)));
    chk("drop_ovf", 64'(overflow), 64'd1);
    chk("drop_lba", 64'(last_break_addr), 64'(15'o03020));
    chk("drop_lbd", 64'(last_break_data), 64'd16);

    // 17 breaks, wrap mode
    do_clear();
    chk("clr_ovf", 64'(overflow), 64'd0);
    wrap_mode = 1'b1;
    for (int i = 0; i < 17; i++) begin
      brk(15'o03000 + 15'(i), 12'(i), i[0], 1'b0, 1'b0);
    end
    chk("wrap_count", 64'(rd.count), 64'd16);
    chk("wrap_head", 64'(rd.rd_data), 64'(ent(1)));
    chk("wrap_ovf", 64'(overflow), 64'd1);

    // asynchronous reset mid-stream
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    chk("arst_count", 64'(rd.count), 64'd0);
    chk("arst_valid", 64'(rd.rd_valid), 64'd0);
    chk("arst_data", 64'(rd.rd_data), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    chk("arst_lba", 64'(last_break_addr), 64'd0);
    chk("arst_lbd", 64'(last_break_data), 64'd0);
    @(negedge clk);
    rst_l = 1'b1;

    // full, then event with pop in the same cycle
    wrap_mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      brk(15'o03000 + 15'(i), 12'(i), i[0], 1'b0, 1'b0);
    end
    chk("full_count", 64'(rd.count), 64'd16);
    chk("full_ovf", 64'(overflow), 64'd0);
    brk(15'o03020, 12'd16, 1'b0, 1'b1, 1'b0);
    chk("fpop_count", 64'(rd.count), 64'd16);
    chk("fpop_ovf", 64'(overflow), 64'd0);
    chk("fpop_head", 64'(rd.rd_data), 64'(ent(1)));
    brk(15'o03021, 12'd17, 1'b1, 1'b0, 1'b0);
    chk("fdrop_ovf", 64'(overflow), 64'd1);
    chk("fdrop_count", 64'(rd.count), 64'd16);

    // clear wins over a simultaneous event
    brk(15'o04000, 12'o4444, 1'b1, 1'b0, 1'b1);
    chk("clrev_count", 64'(rd.count), 64'd0);
    chk("clrev_ovf", 64'(overflow), 64'd0);
    chk("clrev_valid", 64'(rd.rd_valid), 64'd0);

    // capture disabled
    trace_en = 1'b0;
    brk(15'o05000, 12'o0001, 1'b1, 1'b0, 1'b0);
    chk("dis_count", 64'(rd.count), 64'd0);
    trace_en = 1'b1;

`ifdef BREAK_TRACE_FILTER_EN
    win_lo = 15'o07750;
    win_hi = 15'o07757;
    brk(15'o07754, 12'o0123, 1'b1, 1'b0, 1'b0);
    chk("flt_in_count", 64'(rd.count), 64'd1);
    chk("flt_in_lba", 64'(last_break_addr), 64'(15'o07754));
    brk(15'o00010, 12'o0321, 1'b1, 1'b0, 1'b0);
    chk("flt_out_count", 64'(rd.count), 64'd1);
    chk("flt_out_lba", 64'(last_break_addr), 64'(15'o07754));
    chk("flt_head", 64'(rd.rd_data), 64'({1'b1, 15'o07754, 12'o0123}));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
